// File: rtl/veer_types.sv
// veer_types: shared FP scheduler types (op codes, FSM states, queue entry).
package veer_types;

    typedef enum logic [3:0] {
        FPU_FMADD    = 4'd0,
        FPU_FNMSUB   = 4'd1,
        FPU_ADD      = 4'd2,
        FPU_MUL      = 4'd3,
        FPU_DIV      = 4'd4,
        FPU_SQRT     = 4'd5,
        FPU_SGNJ     = 4'd6,
        FPU_MINMAX   = 4'd7,
        FPU_CMP      = 4'd8,
        FPU_CLASSIFY = 4'd9,
        FPU_F2I      = 4'd10,
        FPU_I2F      = 4'd11,
        FPU_F2F      = 4'd12
    } fpu_sched_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fpu_sched_state_e;

    typedef struct packed {
        fpu_sched_op_e op;
        logic          op_mod;
        logic [2:0]    rm;
        logic [95:0]   operands;
    } fpu_sched_entry_t;

    localparam logic [2:0] RM_DYN = 3'b111;

    // Dynamic rounding mode takes the live fcsr value at enqueue time.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

endpackage

// File: rtl/exu_fpu_sched_fifo.sv
// exu_fpu_sched_fifo: power-of-two issue queue with push/pop/clear and
// full/empty derived from a registered occupancy count.
module exu_fpu_sched_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign dout    = mem[rd_ptr];

    // Pointers are AW bits wide, so wrapping modulo DEPTH is free.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/exu_fpu_sched.sv
// exu_fpu_sched: FP issue queue + single-in-flight scheduler to the FPU core.
// Optional exception-flag accumulation enabled by macro RV_FPU_FFLAGS_EN.
module exu_fpu_sched
    import veer_types::*;
#(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic            req_op_mod,
    input  logic [2:0]      req_rm,
    input  logic [TAGW-1:0] req_tag,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [31:0]     req_c,
    input  logic [2:0]      frm,
    input  logic            flush_lower,
    output logic            fpu_in_valid,
    input  logic            fpu_in_ready,
    output logic [3:0]      fpu_op,
    output logic            fpu_op_mod,
    output logic [2:0]      fpu_rm,
    output logic [95:0]     fpu_operands,
    input  logic            fpu_out_valid,
    input  logic [31:0]     fpu_result,
    input  logic [4:0]      fpu_status,
    input  logic            fpu_busy,
    output logic            fpu_out_ready,
    output logic            fpu_flush,
    output logic            wb_valid,
    output logic [TAGW-1:0] wb_tag,
    output logic [31:0]     wb_data,
    input  logic            fflags_clr,
    output logic [4:0]      fflags,
    output logic            sched_busy
);

    localparam int EW = $bits(fpu_sched_entry_t);

    fpu_sched_state_e  state;
    fpu_sched_entry_t  push_entry;
    fpu_sched_entry_t  head;
    logic [TAGW-1:0]   head_tag;
    logic [TAGW-1:0]   cur_tag;
    logic [EW+TAGW-1:0] q_out;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wb_fire;

    assign push_entry = '{op:       fpu_sched_op_e'(req_op),
                          op_mod:   req_op_mod,
                          rm:       resolve_rm(req_rm, frm),
                          operands: {req_c, req_b, req_a}};

    assign req_ready = ~full & ~flush_lower;
    assign push      = req_valid & req_ready;
    assign pop       = (state == S_ISSUE) & fpu_in_ready;
    assign wb_fire   = (state == S_WAIT) & fpu_out_valid & ~flush_lower;

    exu_fpu_sched_fifo #(.DEPTH(DEPTH), .W(EW + TAGW)) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (push),
        .pop   (pop),
        .clear (flush_lower),
        .din   ({req_tag, push_entry}),
        .dout  (q_out),
        .full  (full),
        .empty (empty)
    );

    // Head is masked outside ISSUE so the uninitialised queue RAM never leaks out.
    assign fpu_in_valid  = state == S_ISSUE;
    assign head          = fpu_in_valid ? q_out[EW-1:0] : '0;
    assign head_tag      = q_out[EW+TAGW-1:EW];
    assign fpu_op        = head.op;
    assign fpu_op_mod    = head.op_mod;
    assign fpu_rm        = head.rm;
    assign fpu_operands  = head.operands;
    assign fpu_out_ready = 1'b1;
    assign sched_busy    = ~empty | (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= S_IDLE;
            cur_tag   <= '0;
            wb_valid  <= 1'b0;
            wb_tag    <= '0;
            wb_data   <= '0;
            fpu_flush <= 1'b0;
        end else begin
            wb_valid  <= wb_fire;
            fpu_flush <= flush_lower;
            if (wb_fire) begin
                wb_tag  <= cur_tag;
                wb_data <= fpu_result;
            end
            case (state)
                S_IDLE:  if (!empty && !flush_lower) state <= S_ISSUE;
                S_ISSUE: begin
                    if (fpu_in_ready) begin
                        cur_tag <= head_tag;
                        state   <= flush_lower ? S_DRAIN : S_WAIT;
                    end else if (flush_lower) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (fpu_out_valid)
                        state <= (!flush_lower && !empty) ? S_ISSUE : S_IDLE;
                    else if (flush_lower)
                        state <= S_DRAIN;
                end
                S_DRAIN: if (!fpu_busy && !fpu_out_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RV_FPU_FFLAGS_EN
    // A clear and a same-cycle status merge: clear first, then OR.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) fflags <= '0;
        else        fflags <= (fflags_clr ? 5'b0 : fflags) | (wb_fire ? fpu_status : 5'b0);
    end
`else
    logic unused_flags;
    assign unused_flags = ^{fflags_clr, fpu_status};
    assign fflags       = '0;
`endif

endmodule
